y86_fetch_queue: RTL and testbench
==================================

# y86_fetch_queue

Parametrised Y86-64 fetch unit for the SEQ/PIPE datapaths, replacing single-cycle 10-byte fetch with a prefetching byte queue. Issues fixed-width reads to an external instruction-memory port, buffers bytes, decodes instruction boundaries, and hands decoded fields to decode over a valid/ready handshake. Supports PC redirect (jump/call/ret), ifun legality checks, little-endian valC, and end-of-memory error reporting.

## Interface
- IMEM_BYTES, 1024: instruction memory size in bytes; valid addresses 0..IMEM_BYTES-1.
- FETCH_BYTES, 4: bytes per memory read, 1..10.
- BUF_BYTES, 16: byte queue depth; must be >= 10 + FETCH_BYTES.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  read request this cycle.
- imem_addr  out  64  read byte address (fa).
- imem_rdata  in  8*FETCH_BYTES  data for the request of the previous cycle; byte k at rdata[8k+7:8k] = mem[addr+k].
- redirect_valid  in  1  load new PC, flush queue.
- redirect_pc  in  64  new PC.
- out_valid  out  1  decoded record held.
- out_ready  in  1  decode accepts record.
- icode, ifun, rA, rB  out  4 each  instruction fields.
- valC  out  64  constant, little-endian.
- valP  out  64  PC of next sequential instruction.
- pc  out  64  PC of this record.
- instr_valid  out  1  legal instruction.
- imem_error  out  1  bytes outside memory.
- halt  out  1  record is halt (icode 0).

## Operation
- State: fa (next read address), pc (head instruction address), queue count 0..BUF_BYTES, mode RUN/STOP, output record register.
- Reset: fa=pc=0, count=0, mode RUN, out_valid=0, all record outputs 0, imem_req=0.
- Issue: imem_req=1 when RUN, no redirect, fa<IMEM_BYTES, count + FETCH_BYTES*(1+inflight) <= BUF_BYTES (inflight = read issued previous cycle). fa += FETCH_BYTES per issue.
- Push: returned bytes appended in address order; bytes at address >= IMEM_BYTES dropped.
- Length by head icode: 0,1,9 → 1; 2,6,A,B → 2; 7,8 → 9; 3,4,5 → 10; other → illegal, length 1.
- Fields: rA/rB from byte 1 for lengths 2 and 10, else 0xF. valC = bytes 2..9 (icode 3,4,5) or bytes 1..8 (7,8), little-endian; else 0. valP = pc + length.
- Record load: when head has length bytes available and (out_valid=0 or out_ready=1): load record, pop length bytes, pc=valP.
- Halt, illegal instr (instr_valid=0), or imem_error record → mode STOP: no further reads or records until redirect or reset.
- imem_error: pc>=IMEM_BYTES, or pc+length>IMEM_BYTES → record with imem_error=1, instr_valid=0, icode/ifun from byte 0 if present else 0, valP=pc.
- Redirect in cycle t: imem_req=0 in t; end of t: count=0, fa=pc=redirect_pc, mode RUN, out_valid=0. Data arriving in t dropped (clear beats push). A record accepted (out_valid&out_ready) in t counts as delivered.
- Reset mid-operation overrides everything, including redirect.

## Timing
- Reset low in cycle 0: imem_req=1 in cycle 0; data pushed end of cycle 1; first out_valid=1 in cycle 3 if the instruction fits in one read.
- Redirect in t: first imem_req at redirect_pc in t+1, first record earliest t+4.
- Peak throughput one record per cycle when queue sufficiently filled.
- Record stable while out_valid=1 and out_ready=0.

## Configuration
- FETCH_IFUN_CHECK_EN defined: instr_valid=0 for ifun>6 (icode 2,7), ifun>3 (icode 6), ifun!=0 (icodes 0,1,3,4,5,8,9,A,B); such records stop fetch.
- Undefined: only icode checked; any ifun accepted with instr_valid=1.

## Test plan
- Program 10 / 60 23 / 30 F2 10 00 00 00 00 00 00 00 / 00 → records (1,pc0,valP1), (6,0,rA2,rB3,valP3), (3,rA F,rB2,valC 0x10,valP13), (halt=1,valP14); no imem_req afterward.
- Same program, out_ready=0 for 20 cycles → first record held stable, count never > BUF_BYTES, imem_req stops; records resume in order on release.
- Redirect to 0x40 (80 + dest 0x100 LE) while stalled → stale record dropped, next record pc=0x40, icode 8, valC 0x100, valP 0x49.
- Byte 0xC0 at 0 → instr_valid=0, valP 1, STOP; byte 0x27 → invalid with FETCH_IFUN_CHECK_EN, valid ifun 7 without.
- irmovq at IMEM_BYTES-4 → imem_error=1, instr_valid=0, valP=IMEM_BYTES-4; redirect to 0 resumes.
- reset asserted mid-stream with redirect_valid=1 → out_valid=0 next cycle, restart fetch at 0.

Source files
------------

// File: rtl/y86_fetch_queue_if.sv
// y86_fetch_queue_if: instruction-memory port, redirect and decoded-record handshake of the fetch queue.
interface y86_fetch_queue_if #(parameter int FETCH_BYTES = 4);
  logic imem_req;
  logic [63:0] imem_addr;
  logic [8*FETCH_BYTES-1:0] imem_rdata;
  logic redirect_valid;
  logic [63:0] redirect_pc;
  logic out_valid, out_ready;
  logic [3:0] icode, ifun, rA, rB;
  logic [63:0] valC, valP, pc;
  logic instr_valid, imem_error, halt;
  modport master (
    output imem_req, imem_addr, out_valid, icode, ifun, rA, rB, valC, valP, pc, instr_valid, imem_error, halt,
    input imem_rdata, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input imem_req, imem_addr, out_valid, icode, ifun, rA, rB, valC, valP, pc, instr_valid, imem_error, halt,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/y86_fetch_queue.sv
// y86_fetch_queue: prefetching Y86-64 fetch unit with byte queue and decoded-record handshake.
// Define FETCH_IFUN_CHECK_EN to also reject out-of-range ifun values per icode.
module y86_fetch_queue #(
  parameter int IMEM_BYTES = 1024,
  parameter int FETCH_BYTES = 4,
  parameter int BUF_BYTES = 16
) (
  input logic clk,
  input logic reset,
  y86_fetch_queue_if.master bus
);
  localparam int CW = $clog2(BUF_BYTES + 1);
  localparam logic [63:0] IMEM = 64'(IMEM_BYTES);
  typedef enum logic {RUN, STOP} mode_t;
  mode_t mode, mode_n;
  logic [63:0] fa, head_pc, req_addr, val_p;
  logic [CW-1:0] count;
  logic inflight, issue, legal, err, load;
  logic [8*BUF_BYTES-1:0] qv, qv_n;
  logic [3:0] h_icode, h_ifun, len;
  int cnt, pop, n_push;
  assign bus.imem_req = issue;
  assign bus.imem_addr = fa;
  always_comb begin
    cnt = int'(count);
    h_icode = count != '0 ? qv[7:4] : 4'h0;
    h_ifun = count != '0 ? qv[3:0] : 4'h0;
    len = h_icode inside {4'h3, 4'h4, 4'h5} ? 4'd10 :
          h_icode inside {4'h7, 4'h8} ? 4'd9 :
          h_icode inside {4'h2, 4'h6, 4'hA, 4'hB} ? 4'd2 : 4'd1;
`ifdef FETCH_IFUN_CHECK_EN
    legal = h_icode inside {4'h2, 4'h7} ? h_ifun <= 4'd6 :
            h_icode == 4'h6 ? h_ifun <= 4'd3 : h_icode <= 4'hB && h_ifun == 4'h0;
`else
    legal = h_icode <= 4'hB;
`endif
    // pc beyond memory is an error even before any byte arrives
    err = head_pc >= IMEM || (count != '0 && head_pc + 64'(len) > IMEM);
    val_p = err ? head_pc : head_pc + 64'(len);
    load = mode == RUN && !bus.redirect_valid && (err || cnt >= int'(len)) && (!bus.out_valid || bus.out_ready);
    pop = load && !err ? int'(len) : 0;
    n_push = !inflight || bus.redirect_valid ? 0 :
             IMEM - req_addr >= 64'(FETCH_BYTES) ? FETCH_BYTES : int'(IMEM - req_addr);
    issue = mode == RUN && !reset && !bus.redirect_valid && fa < IMEM &&
            cnt + FETCH_BYTES * (1 + int'(inflight)) <= BUF_BYTES;
    mode_n = bus.redirect_valid ? RUN : load && (err || !legal || h_icode == 4'h0) ? STOP : mode;
    qv_n = qv >> (8 * pop);
    for (int i = 0; i < BUF_BYTES; i++)
      for (int k = 0; k < FETCH_BYTES; k++)
        if (k < n_push && i == cnt - pop + k) qv_n[8*i +: 8] = bus.imem_rdata[8*k +: 8];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mode <= RUN;
      fa <= '0;
      head_pc <= '0;
      req_addr <= '0;
      count <= '0;
      inflight <= 1'b0;
      qv <= '0;
      bus.out_valid <= 1'b0;
      bus.icode <= '0;
      bus.ifun <= '0;
      bus.rA <= '0;
      bus.rB <= '0;
      bus.valC <= '0;
      bus.valP <= '0;
      bus.pc <= '0;
      bus.instr_valid <= 1'b0;
      bus.imem_error <= 1'b0;
      bus.halt <= 1'b0;
    end else begin
      mode <= mode_n;
      inflight <= issue;
      if (issue) begin
        req_addr <= fa;
        fa <= fa + 64'(FETCH_BYTES);
      end
      if (bus.redirect_valid) begin
        fa <= bus.redirect_pc;
        head_pc <= bus.redirect_pc;
        count <= '0;
        bus.out_valid <= 1'b0;
      end else begin
        count <= CW'(cnt - pop + n_push);
        qv <= qv_n;
        if (load) begin
          bus.out_valid <= 1'b1;
          bus.icode <= h_icode;
          bus.ifun <= h_ifun;
          bus.rA <= !err && (len == 4'd2 || len == 4'd10) ? qv[15:12] : 4'hF;
          bus.rB <= !err && (len == 4'd2 || len == 4'd10) ? qv[11:8] : 4'hF;
          bus.valC <= err ? '0 : len == 4'd10 ? qv[79:16] : len == 4'd9 ? qv[71:8] : '0;
          bus.valP <= val_p;
          bus.pc <= head_pc;
          bus.instr_valid <= !err && legal;
          bus.imem_error <= err;
          bus.halt <= !err && h_icode == 4'h0;
          head_pc <= val_p;
        end else if (bus.out_ready) bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_y86_fetch_queue.sv
// tb_y86_fetch_queue: directed self-checking bench for y86_fetch_queue with a 1 KiB memory model.
module tb_y86_fetch_queue;
  typedef struct packed {
    logic [3:0] icode, ifun, ra, rb;
    logic [63:0] valc, valp, pc;
    logic iv, me, h;
  } rec_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] mem [1024];
  rec_t recs [8];
  rec_t prog [4];
  int got, total, bad;
  y86_fetch_queue_if #(.FETCH_BYTES(4)) bus ();
  y86_fetch_queue #(.IMEM_BYTES(1024), .FETCH_BYTES(4), .BUF_BYTES(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk)
    for (int k = 0; k < 4; k++)
      bus.imem_rdata[8*k +: 8] <= bus.imem_addr + 64'(k) < 64'd1024 ? mem[10'(bus.imem_addr + 64'(k))] : 8'h00;
  function automatic rec_t mk(input logic [3:0] ic, fn, ra, rb, input logic [63:0] vc, vp, p, input logic iv, me, h);
    return {ic, fn, ra, rb, vc, vp, p, iv, me, h};
  endfunction
  function automatic rec_t cur();
    return mk(bus.icode, bus.ifun, bus.rA, bus.rB, bus.valC, bus.valP, bus.pc, bus.instr_valid, bus.imem_error, bus.halt);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load_prog();
    foreach (mem[i]) mem[i] = 8'h00;
    mem[0] = 8'h10; mem[1] = 8'h60; mem[2] = 8'h23; mem[3] = 8'h30; mem[4] = 8'hF2; mem[5] = 8'h10;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask
  task automatic collect(input int n);
    got = 0;
    foreach (recs[i]) recs[i] = '0;
    for (int c = 0; c < 100 && got < n; c++) begin
      if (bus.out_valid && bus.out_ready) begin
        recs[got] = cur();
        got++;
      end
      step();
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_imem_req: got %b want 0", bus.imem_req); end
    total++; if (cur() !== rec_t'('0)) begin bad++; $display("FAIL reset_record: got %h want 0", cur()); end
  endtask
  task automatic test_program();
    load_prog();
    bus.out_ready = 1'b1;
    do_reset();
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'd0) begin bad++; $display("FAIL first_req: got %b@%h want 1@0", bus.imem_req, bus.imem_addr); end
    for (int c = 1; c <= 3; c++) begin
      step();
      total++; if (bus.out_valid !== (c == 3)) begin bad++; $display("FAIL first_valid_c%0d: got %b want %b", c, bus.out_valid, c == 3); end
    end
    collect(4);
    total++; if (got !== 4) begin bad++; $display("FAIL prog_count: got %0d want 4", got); end
    for (int i = 0; i < 4; i++) begin
      total++; if (recs[i] !== prog[i]) begin bad++; $display("FAIL prog_rec%0d: got %h want %h", i, recs[i], prog[i]); end
    end
    for (int c = 0; c < 10; c++) begin
      total++; if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL halt_stop: got req=%b valid=%b want 0 0", bus.imem_req, bus.out_valid); end
      step();
    end
  endtask
  task automatic test_stall();
    bit seen = 0;
    load_prog();
    bus.out_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      total++; if (dut.count > 5'd16) begin bad++; $display("FAIL stall_count: got %0d want <=16", dut.count); end
      if (bus.out_valid) begin
        seen = 1;
        total++; if (cur() !== prog[0]) begin bad++; $display("FAIL stall_hold: got %h want %h", cur(), prog[0]); end
      end
      step();
    end
    total++; if (!seen) begin bad++; $display("FAIL stall_seen: got 0 want 1"); end
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL stall_req_stop: got %b want 0", bus.imem_req); end
    bus.out_ready = 1'b1;
    collect(4);
    for (int i = 0; i < 4; i++) begin
      total++; if (recs[i] !== prog[i]) begin bad++; $display("FAIL stall_rec%0d: got %h want %h", i, recs[i], prog[i]); end
    end
  endtask
  task automatic test_redirect();
    load_prog();
    mem[64] = 8'h80; mem[65] = 8'h00; mem[66] = 8'h01;
    bus.out_ready = 1'b0;
    do_reset();
    step(); step(); step();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL redir_stale_valid: got %b want 1", bus.out_valid); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h40;
    #1;
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL redir_req_t: got %b want 0", bus.imem_req); end
    step();
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL redir_flush: got %b want 0", bus.out_valid); end
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h40) begin bad++; $display("FAIL redir_req: got %b@%h want 1@40", bus.imem_req, bus.imem_addr); end
    collect(1);
    total++; if (recs[0] !== mk(4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 64'h49, 64'h40, 1, 0, 0)) begin bad++; $display("FAIL redir_rec: got %h want call 0x100 at 0x40", recs[0]); end
  endtask
  task automatic test_illegal();
    foreach (mem[i]) mem[i] = 8'h00;
    mem[0] = 8'hC0;
    bus.out_ready = 1'b1;
    do_reset();
    collect(1);
    total++; if (recs[0] !== mk(4'hC, 4'h0, 4'hF, 4'hF, 0, 1, 0, 0, 0, 0)) begin bad++; $display("FAIL illegal_rec: got %h want icode C invalid valP 1", recs[0]); end
    for (int c = 0; c < 8; c++) begin
      total++; if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL illegal_stop: got req=%b valid=%b want 0 0", bus.imem_req, bus.out_valid); end
      step();
    end
    mem[0] = 8'h27;
    mem[1] = 8'h12;
    do_reset();
    collect(1);
`ifdef FETCH_IFUN_CHECK_EN
    total++; if (recs[0] !== mk(4'h2, 4'h7, 4'h1, 4'h2, 0, 2, 0, 0, 0, 0)) begin bad++; $display("FAIL ifun_rec: got %h want ifun 7 invalid", recs[0]); end
`else
    total++; if (recs[0] !== mk(4'h2, 4'h7, 4'h1, 4'h2, 0, 2, 0, 1, 0, 0)) begin bad++; $display("FAIL ifun_rec: got %h want ifun 7 valid", recs[0]); end
`endif
  endtask
  task automatic test_mem_error();
    load_prog();
    mem[1020] = 8'h30;
    mem[1021] = 8'hF3;
    bus.out_ready = 1'b1;
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'd1020;
    step();
    bus.redirect_valid = 1'b0;
    collect(1);
    total++; if (recs[0] !== mk(4'h3, 4'h0, 4'hF, 4'hF, 0, 1020, 1020, 0, 1, 0)) begin bad++; $display("FAIL memerr_rec: got %h want error at 1020", recs[0]); end
    for (int c = 0; c < 5; c++) begin
      total++; if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL memerr_stop: got req=%b valid=%b want 0 0", bus.imem_req, bus.out_valid); end
      step();
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'd0;
    step();
    bus.redirect_valid = 1'b0;
    collect(1);
    total++; if (recs[0] !== prog[0]) begin bad++; $display("FAIL memerr_resume: got %h want %h", recs[0], prog[0]); end
  endtask
  task automatic test_reset_mid();
    load_prog();
    bus.out_ready = 1'b1;
    do_reset();
    step(); step(); step(); step();
    reset = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h40;
    #1;
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rstmid_req: got %b want 0", bus.imem_req); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", bus.out_valid); end
    reset = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'd0) begin bad++; $display("FAIL rstmid_restart: got %b@%h want 1@0", bus.imem_req, bus.imem_addr); end
    step(); step(); step();
    total++; if (!bus.out_valid || cur() !== prog[0]) begin bad++; $display("FAIL rstmid_rec: got v=%b %h want %h", bus.out_valid, cur(), prog[0]); end
  endtask
  initial begin
    total = 0;
    bad = 0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    foreach (mem[i]) mem[i] = 8'h00;
    prog[0] = mk(4'h1, 4'h0, 4'hF, 4'hF, 0, 1, 0, 1, 0, 0);
    prog[1] = mk(4'h6, 4'h0, 4'h2, 4'h3, 0, 3, 1, 1, 0, 0);
    prog[2] = mk(4'h3, 4'h0, 4'hF, 4'h2, 64'h10, 13, 3, 1, 0, 0);
    prog[3] = mk(4'h0, 4'h0, 4'hF, 4'hF, 0, 14, 13, 1, 0, 1);
    test_reset();
    test_program();
    test_stall();
    test_redirect();
    test_illegal();
    test_mem_error();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
